// File: rtl/kyber_intt_core.sv
// kyber_intt_core: in-place Gentleman-Sande inverse NTT over a 256-entry
// coefficient RAM (synchronous read, one-cycle latency), followed by a
// final pass that multiplies every coefficient by 128^-1 mod Q.
module kyber_intt_core #(
  parameter int unsigned Q     = 3329,
  parameter int unsigned N_INV = 3303
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [7:0]  mem_addr,
  output logic        mem_we,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic [6:0]  zeta_idx,
  input  logic [11:0] zeta
);

  typedef enum logic [1:0] {IDLE, BFLY, SCALE, FIN} top_e;
  typedef enum logic [2:0] {RD_U, RD_V, CAP_V, MUL, WR_U, WR_V} bfly_e;
  typedef enum logic [1:0] {S_RD, S_CAP, S_MUL, S_WR} scale_e;

  localparam logic [12:0] Q13       = 13'(Q);
  localparam logic [13:0] Q14       = 14'(Q);
  localparam logic [13:0] Q2_14     = 14'(2 * Q);
  localparam logic [23:0] Q24       = 24'(Q);
  localparam logic [12:0] BARRETT_M = 13'((32'd1 << 24) / Q);
  localparam logic [11:0] NINV12    = 12'(N_INV);

  // (a + b) mod Q for any two 12-bit operands; 2*4095 < 3Q so two steps suffice.
  function automatic logic [11:0] red_sum(input logic [11:0] a, input logic [11:0] b);
    logic [12:0] s;
    s = {1'b0, a} + {1'b0, b};
    s = (s >= Q13) ? s - Q13 : s;
    s = (s >= Q13) ? s - Q13 : s;
    return 12'(s);
  endfunction

  // (v - u) mod Q; biasing by 2Q keeps the intermediate non-negative.
  function automatic logic [11:0] red_diff(input logic [11:0] u, input logic [11:0] v);
    logic [13:0] d;
    d = {2'b00, v} + Q2_14 - {2'b00, u};
    d = (d >= Q2_14) ? d - Q2_14 : d;
    d = (d >= Q14) ? d - Q14 : d;
    return 12'(d);
  endfunction

  // Barrett reduction of a 24-bit product; the quotient estimate is short by
  // at most one, so the remainder needs at most one correction.
  function automatic logic [11:0] mod_q24(input logic [23:0] x);
    logic [12:0] qe;
    logic [23:0] r;
    qe = 13'(({13'd0, x} * {24'd0, BARRETT_M}) >> 24);
    r  = x - ({11'd0, qe} * Q24);
    r  = (r >= Q24) ? r - Q24 : r;
    r  = (r >= Q24) ? r - Q24 : r;
    return 12'(r);
  endfunction

  top_e        top_q, top_d;
  bfly_e       bst_q, bst_d;
  scale_e      sst_q, sst_d;
  logic [7:0]  j_q, j_d;          // butterfly low index, reused as scale index
  logic [2:0]  layer_q, layer_d;  // len = 2 << layer
  logic [6:0]  k_q, k_d;          // twiddle index, counts down per block
  logic [11:0] u_q, u_d;
  logic [11:0] v_q, v_d;
  logic [11:0] sum_q, sum_d;
  logic [11:0] prod_q, prod_d;

  logic [8:0]  len_s;
  logic [7:0]  j_hi_s;
  logic [8:0]  j_inc_s;
  logic        blk_end_s;
  logic [8:0]  j_nxt_s;
  logic        unused_rdata_hi_s;

  assign len_s     = 9'd2 << layer_q;
  assign j_hi_s    = j_q + len_s[7:0];
  assign j_inc_s   = {1'b0, j_q} + 9'd1;
  // A block ends when the low index reaches the next multiple of len.
  assign blk_end_s = ((j_inc_s & (len_s - 9'd1)) == 9'd0);
  // At a block end skip over the upper half; passing 255 ends the layer.
  assign j_nxt_s   = blk_end_s ? (j_inc_s + len_s) : j_inc_s;
  assign unused_rdata_hi_s = ^mem_rdata[15:12];

  // State, counter and datapath registers; reset returns to a cleared idle state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      top_q   <= IDLE;
      bst_q   <= RD_U;
      sst_q   <= S_RD;
      j_q     <= 8'd0;
      layer_q <= 3'd0;
      k_q     <= 7'd127;
      u_q     <= 12'd0;
      v_q     <= 12'd0;
      sum_q   <= 12'd0;
      prod_q  <= 12'd0;
    end else begin
      top_q   <= top_d;
      bst_q   <= bst_d;
      sst_q   <= sst_d;
      j_q     <= j_d;
      layer_q <= layer_d;
      k_q     <= k_d;
      u_q     <= u_d;
      v_q     <= v_d;
      sum_q   <= sum_d;
      prod_q  <= prod_d;
    end
  end

  // Next-state logic: butterfly and scale sequencing plus operand capture and arithmetic.
  always_comb begin
    top_d   = top_q;
    bst_d   = bst_q;
    sst_d   = sst_q;
    j_d     = j_q;
    layer_d = layer_q;
    k_d     = k_q;
    u_d     = u_q;
    v_d     = v_q;
    sum_d   = sum_q;
    prod_d  = prod_q;
    case (top_q)
      IDLE, FIN: begin
        if (start) begin
          top_d   = BFLY;
          bst_d   = RD_U;
          sst_d   = S_RD;
          j_d     = 8'd0;
          layer_d = 3'd0;
          k_d     = 7'd127;
        end else begin
          top_d = top_q;
        end
      end
      BFLY: begin
        case (bst_q)
          RD_U:  bst_d = RD_V;
          RD_V:  begin u_d = mem_rdata[11:0]; bst_d = CAP_V; end
          CAP_V: begin v_d = mem_rdata[11:0]; bst_d = MUL; end
          MUL: begin
            sum_d  = red_sum(u_q, v_q);
            prod_d = mod_q24({12'd0, red_diff(u_q, v_q)} * {12'd0, zeta});
            bst_d  = WR_U;
          end
          WR_U:  bst_d = WR_V;
          WR_V: begin
            bst_d = RD_U;
            if (blk_end_s) begin
              k_d = k_q - 7'd1;
            end else begin
              k_d = k_q;
            end
            if (j_nxt_s[8]) begin
              j_d = 8'd0;
              if (layer_q == 3'd6) begin
                top_d = SCALE;
                sst_d = S_RD;
              end else begin
                layer_d = layer_q + 3'd1;
              end
            end else begin
              j_d = j_nxt_s[7:0];
            end
          end
          default: bst_d = RD_U;
        endcase
      end
      SCALE: begin
        case (sst_q)
          S_RD:  sst_d = S_CAP;
          S_CAP: begin u_d = mem_rdata[11:0]; sst_d = S_MUL; end
          S_MUL: begin
            prod_d = mod_q24({12'd0, u_q} * {12'd0, NINV12});
            sst_d  = S_WR;
          end
          S_WR: begin
            sst_d = S_RD;
            if (j_q == 8'd255) begin
              top_d = FIN;
              j_d   = 8'd0;
            end else begin
              j_d = j_q + 8'd1;
            end
          end
          default: sst_d = S_RD;
        endcase
      end
      default: top_d = IDLE;
    endcase
  end

  // Output decode from the registered state: RAM port, status and twiddle index.
  always_comb begin
    busy      = 1'b0;
    done      = 1'b0;
    mem_addr  = 8'd0;
    mem_we    = 1'b0;
    mem_wdata = 16'd0;
    zeta_idx  = k_q;
    case (top_q)
      BFLY: begin
        busy = 1'b1;
        case (bst_q)
          RD_U: mem_addr = j_q;
          RD_V: mem_addr = j_hi_s;
          WR_U: begin
            mem_addr  = j_q;
            mem_we    = 1'b1;
            mem_wdata = {4'd0, sum_q};
          end
          WR_V: begin
            mem_addr  = j_hi_s;
            mem_we    = 1'b1;
            mem_wdata = {4'd0, prod_q};
          end
          default: mem_addr = 8'd0;
        endcase
      end
      SCALE: begin
        busy = 1'b1;
        case (sst_q)
          S_RD: mem_addr = j_q;
          S_WR: begin
            mem_addr  = j_q;
            mem_we    = 1'b1;
            mem_wdata = {4'd0, prod_q};
          end
          default: mem_addr = 8'd0;
        endcase
      end
      FIN:     done = 1'b1;
      default: done = 1'b0;
    endcase
  end

endmodule
